// File: rtl/seq_match_pkg.sv
// Shared types and default constants for the sequence-matching arbiter.
package seq_match_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int          DEF_NUM_REQ     = 4;
  localparam int          DEF_DIGIT_W     = 4;
  localparam int          DEF_SEQ_LEN     = 4;
  localparam logic [15:0] DEF_RST_PATTERN = 16'h1094;

endpackage

// File: rtl/seq_match_core.sv
// Digit-serial comparator: counts SEQ_LEN digits and ANDs per-digit equality.
module seq_match_core
  import seq_match_pkg::*;
#(
  parameter int DIGIT_W = DEF_DIGIT_W,
  parameter int SEQ_LEN = DEF_SEQ_LEN
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               i_start,
  input  logic               i_step,
  input  logic [DIGIT_W-1:0] i_digit,
  input  logic [DIGIT_W-1:0] i_pat_digit,
  output logic               o_done,
  output logic               o_match
);

  localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  logic [IDX_W-1:0] r_idx;
  logic             r_acc;
  logic             w_eq;

  assign w_eq    = (i_digit == i_pat_digit);
  // Match including the digit being compared this cycle.
  assign o_match = r_acc & w_eq;
  assign o_done  = i_step && (r_idx == IDX_W'(SEQ_LEN - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_idx <= '0;
      r_acc <= 1'b0;
    end else if (i_start) begin
      r_idx <= '0;
      r_acc <= 1'b1;
    end else if (i_step) begin
      r_acc <= o_match;
      r_idx <= o_done ? '0 : r_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/seq_match_arbiter.sv
// Round-robin arbiter feeding requester frames into one shared digit matcher,
// returning one tagged match/no-match response per accepted frame.
module seq_match_arbiter
  import seq_match_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DIGIT_W = DEF_DIGIT_W,
  parameter int SEQ_LEN = DEF_SEQ_LEN,
  parameter logic [SEQ_LEN*DIGIT_W-1:0] RST_PATTERN = DEF_RST_PATTERN
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*SEQ_LEN*DIGIT_W-1:0]  req_digits,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic                                cfg_we,
  input  logic [SEQ_LEN*DIGIT_W-1:0]          cfg_pattern,
  output logic                                rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]          rsp_id,
  output logic                                rsp_match,
  input  logic                                rsp_ready,
  output logic                                busy
);

  localparam int FRAME_W = SEQ_LEN * DIGIT_W;
  localparam int ID_W    = $clog2(NUM_REQ);

  state_t             r_state;
  logic [ID_W-1:0]    r_ptr;
  logic [FRAME_W-1:0] r_pattern;
  logic [FRAME_W-1:0] r_frame;
  logic [FRAME_W-1:0] r_snap;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic               r_rsp_match;

  logic               w_any;
  logic [ID_W-1:0]    w_grant;
  logic [ID_W-1:0]    w_cand;
  logic               w_accept;
  logic               w_done;
  logic               w_match;

  // First valid requester scanning upward from the pointer, wrapping.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_any && req_valid[w_cand]) begin
        w_any   = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  assign w_accept  = reset_n && (r_state == IDLE) && w_any;
  assign req_ready = w_accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_grant) : '0;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_match = r_rsp_match;
  assign busy      = (r_state != IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_pattern   <= RST_PATTERN;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_match <= 1'b0;
    end else begin
      if (cfg_we) r_pattern <= cfg_pattern;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state  <= FEED;
            r_rsp_id <= w_grant;
            r_ptr    <= (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + ID_W'(1);
          end
        end
        FEED: begin
          if (w_done) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_match <= w_match;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Frame and pattern snapshot shift left so the top digit is always the one under compare.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_frame <= req_digits[int'(w_grant)*FRAME_W +: FRAME_W];
      r_snap  <= r_pattern;
    end else if (r_state == FEED) begin
      r_frame <= r_frame << DIGIT_W;
      r_snap  <= r_snap << DIGIT_W;
    end
  end

  seq_match_core #(
    .DIGIT_W(DIGIT_W),
    .SEQ_LEN(SEQ_LEN)
  ) u_core (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_start    (w_accept),
    .i_step     (r_state == FEED),
    .i_digit    (r_frame[FRAME_W-1 -: DIGIT_W]),
    .i_pat_digit(r_snap[FRAME_W-1 -: DIGIT_W]),
    .o_done     (w_done),
    .o_match    (w_match)
  );

endmodule

// File: tb/tb_seq_match_arbiter.sv
// Scoreboard bench for seq_match_arbiter: requester agent, reference model and monitor.
module tb_seq_match_arbiter;

  localparam int          NR   = 4;
  localparam int          SL   = 4;
  localparam int          FW   = 16;
  localparam int          IW   = 2;
  localparam logic [15:0] RSTP = 16'h1094;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*FW-1:0] req_digits = '0;
  logic [NR-1:0]    req_ready;
  logic             cfg_we = 1'b0;
  logic [FW-1:0]    cfg_pattern = '0;
  logic             rsp_valid;
  logic [IW-1:0]    rsp_id;
  logic             rsp_match;
  logic             rsp_ready = 1'b1;
  logic             busy;

  seq_match_arbiter dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_digits(req_digits),
    .req_ready(req_ready), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_match(rsp_match),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct { int id; logic [FW-1:0] frame; } frm_t;
  typedef struct { int id; logic match; int cyc; } exp_t;
  typedef struct { int id; int cyc; } acc_t;

  frm_t frame_q[$];
  exp_t sb_q[$];
  acc_t acc_log[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  int            mdl_ptr = 0;
  logic [FW-1:0] mdl_pat = RSTP;
  logic          pending = 1'b0;
  logic [IW-1:0] held_id = '0;
  logic          held_match = 1'b0;
  int            last_acc = -100;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int id, input logic [FW-1:0] f);
    frame_q.push_back('{id: id, frame: f});
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while ((frame_q.size() > 0 || sb_q.size() > 0 || busy || (|req_valid)) && n < budget) begin
      @(negedge clock); #2;
      n++;
    end
    chk(name, n < budget, 1);
  endtask

  task automatic wait_accept(input int n0, input int budget);
    int n;
    n = 0;
    while (acc_log.size() <= n0 && n < budget) begin
      @(negedge clock); #2;
      n++;
    end
    chk("accept_timeout", n < budget, 1);
  endtask

  // Requesters: present the next queued frame, hold it until req_ready is seen.
  initial begin
    logic [NR-1:0] g;
    logic          found;
    forever begin
      @(negedge clock);
      g = req_ready;
      @(posedge clock);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (g[i]) req_valid[i] = 1'b0;
        if (!req_valid[i]) begin
          found = 1'b0;
          for (int k = 0; k < frame_q.size(); k++) begin
            if (!found && frame_q[k].id == i) begin
              found = 1'b1;
              req_digits[i*FW +: FW] = frame_q[k].frame;
              req_valid[i] = 1'b1;
              frame_q.delete(k);
            end
          end
        end
      end
    end
  end

  // Reference model and monitor, sampled mid-cycle.
  always @(negedge clock) begin
    int   eg;
    int   j;
    logic found;
    exp_t e;
    chk("busy", busy, sb_q.size() > 0);
    if (!reset_n) begin
      sb_q.delete();
      pending  = 1'b0;
      mdl_ptr  = 0;
      mdl_pat  = RSTP;
      last_acc = -100;
    end else begin
      if (rsp_valid) begin
        if (!pending) begin
          chk("rsp_expected", sb_q.size() > 0, 1);
          if (sb_q.size() > 0) chk("latency", cyc - sb_q[0].cyc, SL + 1);
          pending    = 1'b1;
          held_id    = rsp_id;
          held_match = rsp_match;
        end else begin
          chk("rsp_id_stable", rsp_id, held_id);
          chk("rsp_match_stable", rsp_match, held_match);
        end
        if (rsp_ready && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_match", rsp_match, e.match);
          pending = 1'b0;
        end
      end
      if (req_ready != '0) begin
        found = 1'b0;
        eg    = 0;
        for (int k = 0; k < NR; k++) begin
          j = (mdl_ptr + k) % NR;
          if (!found && req_valid[j]) begin
            found = 1'b1;
            eg    = j;
          end
        end
        chk("grant", req_ready, 32'd1 << eg);
        chk("grant_gap_ok", (cyc - last_acc) >= SL + 2, 1);
        if (found) begin
          sb_q.push_back('{id: eg, match: (req_digits[eg*FW +: FW] == mdl_pat), cyc: cyc});
          acc_log.push_back('{id: eg, cyc: cyc});
          mdl_ptr  = (eg + 1) % NR;
          last_acc = cyc;
        end
      end
      if (cfg_we) mdl_pat = cfg_pattern;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    int n0;
    int sel;
    int n;
    logic [FW-1:0] f;

    repeat (3) tick();
    @(negedge clock);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_match", rsp_match, 0);
    chk("rst_busy", busy, 0);
    tick();
    reset_n = 1'b1;

    // Single match, then two mismatches from requester 2.
    send(0, 16'h1094);
    drain(60, "single_done");
    send(2, 16'h1095);
    drain(60, "mismatch1_done");
    send(2, 16'h4901);
    drain(60, "mismatch2_done");

    // Fairness from a freshly reset pointer.
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    acc_log.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) send(i, 16'($urandom));
    drain(200, "fair_done");
    chk("fair_count", acc_log.size(), 2 * NR);
    for (int k = 0; k < acc_log.size(); k++) begin
      chk("fair_order", acc_log[k].id, k % NR);
      if (k > 0) chk("fair_gap", acc_log[k].cyc - acc_log[k-1].cyc, SL + 2);
    end

    // Pattern rewrite during FEED affects only later frames.
    n0 = acc_log.size();
    send(1, 16'h1094);
    wait_accept(n0, 40);
    tick();
    tick();
    cfg_pattern = 16'h2468;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    drain(60, "reconf1_done");
    send(1, 16'h2468);
    drain(60, "reconf2_done");
    send(1, 16'h1094);
    drain(60, "reconf3_done");

    // Backpressure: response from 0 held while 1 waits.
    tick();
    rsp_ready = 1'b0;
    send(0, 16'h2468);
    send(1, 16'h1234);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("bp_rsp_seen", n < 40, 1);
    repeat (10) begin
      @(negedge clock);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, 0);
      chk("bp_ready", req_ready, 0);
    end
    tick();
    rsp_ready = 1'b1;
    drain(60, "bp_done");
    if (acc_log.size() > 0) chk("bp_regrant", acc_log[acc_log.size()-1].id, 1);

    // Randomized traffic with random backpressure and pattern writes.
    for (int k = 0; k < 24; k++) begin
      sel = $urandom_range(0, 2);
      f = (sel == 0) ? 16'h1094 : (sel == 1) ? 16'h2468 : 16'($urandom);
      send($urandom_range(0, NR - 1), f);
    end
    n = 0;
    while ((frame_q.size() > 0 || sb_q.size() > 0 || busy || (|req_valid)) && n < 3000) begin
      tick();
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        sel = $urandom_range(0, 2);
        cfg_pattern = (sel == 0) ? 16'h1094 : (sel == 1) ? 16'h2468 : 16'($urandom);
        cfg_we = 1'b1;
      end else begin
        cfg_we = 1'b0;
      end
      n++;
    end
    cfg_we = 1'b0;
    rsp_ready = 1'b1;
    drain(100, "random_done");

    // Reset during FEED at digit index 2.
    n0 = acc_log.size();
    send(3, 16'h1094);
    wait_accept(n0, 40);
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_id", rsp_id, 0);
    chk("midrst_rsp_match", rsp_match, 0);
    chk("midrst_busy", busy, 0);
    reset_n = 1'b1;
    repeat (8) begin
      @(negedge clock);
      chk("midrst_no_rsp", rsp_valid, 0);
    end
    send(3, 16'h1094);
    drain(60, "post_rst_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
